// File: rtl/dm_burst_reader.sv
// Burst read initiator for the single-ported data memory: issues consecutive reads
// under FIFO credit and streams the returned words to a valid/ready consumer.
module dm_burst_reader #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_vld,
  output logic              cmd_rdy,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              abort,
  output logic [ADDR_W-1:0] dm_addr,
  output logic              dm_re,
  output logic              dm_we,
  input  logic [DATA_W-1:0] dm_rd_data,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  input  logic              dout_rdy,
  output logic              busy,
  output logic              done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W-1:0] remaining;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [CW:0]       occupancy;
  logic              accept, abort_take, push, pop, credit, issue, drain_done;

  assign cmd_rdy    = (state == IDLE);
  assign busy       = (state != IDLE);
  assign dm_we      = 1'b0;
  assign dout       = mem[rd_ptr];
  assign dout_vld   = (count != '0);
  assign accept     = cmd_vld & cmd_rdy;
  assign abort_take = abort & busy;
  assign pop        = dout_vld & dout_rdy;
  // dm_re marks the read whose data lands in the FIFO at the next edge
  assign push       = dm_re & ~abort_take;
  assign occupancy  = {1'b0, count} + (CW+1)'(dm_re) - (CW+1)'(pop);
  assign credit     = (occupancy < (CW+1)'(FIFO_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    drain_done = 1'b0;
    case (state)
      IDLE: begin
        if (accept && (cmd_len != '0)) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (abort_take) begin
          state_nxt = IDLE;
        end else if (credit) begin
          issue = 1'b1;
          if (remaining == ADDR_W'(1)) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (abort_take) begin
          state_nxt = IDLE;
        end else if (!dm_re && ((count - CW'(pop)) == '0)) begin
          state_nxt  = IDLE;
          drain_done = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dm_addr   <= '0;
      dm_re     <= 1'b0;
      next_addr <= '0;
      remaining <= '0;
      done      <= 1'b0;
    end else begin
      done  <= (accept && (cmd_len == '0)) || abort_take || drain_done;
      dm_re <= issue;
      if (accept) begin
        next_addr <= cmd_addr;
        remaining <= cmd_len;
      end else if (issue) begin
        dm_addr   <= next_addr;
        next_addr <= next_addr + ADDR_W'(1);
        remaining <= remaining - ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (abort_take) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dm_rd_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule
